// File: rtl/hazard_seq_ctrl.sv
// Pipeline hazard/sequencing control: load-use stalls, branch squash, RET penalty, interrupt entry.
// Outputs are combinational from state and inputs; state, counter and in_isr are registered.
module hazard_seq_ctrl #(
  parameter int RET_PENALTY  = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_en_E,
  input  logic       wr_en_regf_E,
  input  logic [1:0] dest_E,
  input  logic [1:0] RA_D,
  input  logic [1:0] RB_D,
  input  logic       uses_ra_D,
  input  logic       uses_rb_D,
  input  logic       branch_taken_E,
  input  logic       is_ret_E,
  input  logic       irq,
  output logic       stall_F,
  output logic       stall_D,
  output logic       flush_D,
  output logic       flush_E,
  output logic       ret_pc_load,
  output logic       int_push_pc,
  output logic       int_push_flags,
  output logic       int_pop_flags,
  output logic       vec_load,
  output logic       irq_ack,
  output logic       in_isr
);

  typedef enum logic [2:0] {
    IDLE, RET_WAIT, INT_DRAIN, INT_PUSH_PC, INT_PUSH_FLG, INT_VEC
  } state_t;

  localparam logic [2:0] RET_INIT   = 3'(RET_PENALTY - 1);
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  state_t     r_state, w_next_state;
  logic [2:0] r_cnt, w_next_cnt;
  logic       r_in_isr, w_next_in_isr;
  logic       w_lu;
  logic       w_stall_F, w_stall_D, w_flush_D, w_flush_E;
  logic       w_ret_pc_load, w_push_pc, w_push_flags, w_pop_flags, w_vec_load, w_irq_ack;

  assign w_lu = rd_en_E & wr_en_regf_E &
                ((uses_ra_D & (RA_D == dest_E)) | (uses_rb_D & (RB_D == dest_E)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_in_isr <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_in_isr <= w_next_in_isr;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_next_in_isr = r_in_isr;
    w_stall_F     = 1'b0;
    w_stall_D     = 1'b0;
    w_flush_D     = 1'b0;
    w_flush_E     = 1'b0;
    w_ret_pc_load = 1'b0;
    w_push_pc     = 1'b0;
    w_push_flags  = 1'b0;
    w_pop_flags   = 1'b0;
    w_vec_load    = 1'b0;
    w_irq_ack     = 1'b0;
    case (r_state)
      IDLE: begin
        if (is_ret_E) begin
          w_stall_F    = 1'b1;
          w_flush_D    = 1'b1;
          w_flush_E    = 1'b1;
          w_next_cnt   = RET_INIT;
          w_next_state = RET_WAIT;
        end else if (branch_taken_E) begin
          w_flush_D = 1'b1;
          w_flush_E = 1'b1;
        end else if (w_lu) begin
          w_stall_F = 1'b1;
          w_stall_D = 1'b1;
          w_flush_E = 1'b1;
        end else if (irq && !r_in_isr) begin
          w_stall_F    = 1'b1;
          w_flush_D    = 1'b1;
          w_next_cnt   = DRAIN_INIT;
          w_next_state = INT_DRAIN;
        end
      end
      RET_WAIT: begin
        w_stall_F = 1'b1;
        w_flush_D = 1'b1;
        w_flush_E = 1'b1;
        if (r_cnt == 3'd0) begin
          w_ret_pc_load = 1'b1;
          w_pop_flags   = r_in_isr;
          w_next_in_isr = 1'b0;
          w_next_state  = IDLE;
        end else begin
          w_next_cnt = r_cnt - 3'd1;
        end
      end
      INT_DRAIN: begin
        // Older EX/MEM instructions retire while nothing new is issued.
        w_stall_F = 1'b1;
        w_flush_D = 1'b1;
        w_flush_E = 1'b1;
        if (r_cnt == 3'd0) w_next_state = INT_PUSH_PC;
        else               w_next_cnt   = r_cnt - 3'd1;
      end
      INT_PUSH_PC: begin
        w_push_pc    = 1'b1;
        w_stall_F    = 1'b1;
        w_flush_E    = 1'b1;
        w_next_state = INT_PUSH_FLG;
      end
      INT_PUSH_FLG: begin
        w_push_flags = 1'b1;
        w_stall_F    = 1'b1;
        w_flush_E    = 1'b1;
        w_next_state = INT_VEC;
      end
      INT_VEC: begin
        w_vec_load    = 1'b1;
        w_irq_ack     = 1'b1;
        w_flush_D     = 1'b1;
        w_flush_E     = 1'b1;
        w_next_in_isr = 1'b1;
        w_next_state  = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is held.
  assign stall_F        = reset & w_stall_F;
  assign stall_D        = reset & w_stall_D;
  assign flush_D        = reset & w_flush_D;
  assign flush_E        = reset & w_flush_E;
  assign ret_pc_load    = reset & w_ret_pc_load;
  assign int_push_pc    = reset & w_push_pc;
  assign int_push_flags = reset & w_push_flags;
  assign int_pop_flags  = reset & w_pop_flags;
  assign vec_load       = reset & w_vec_load;
  assign irq_ack        = reset & w_irq_ack;
  assign in_isr         = reset & r_in_isr;

endmodule

// File: tb/tb_hazard_seq_ctrl.sv
// Directed bench for hazard_seq_ctrl (RET_PENALTY=2, DRAIN_CYCLES=2).
// Output vector order: stall_F stall_D flush_D flush_E ret_pc_load push_pc push_flags pop_flags vec_load irq_ack in_isr
module tb_hazard_seq_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rd_en_E, wr_en_regf_E, uses_ra_D, uses_rb_D, branch_taken_E, is_ret_E, irq;
  logic [1:0] dest_E, RA_D, RB_D;
  logic       stall_F, stall_D, flush_D, flush_E, ret_pc_load, int_push_pc, int_push_flags;
  logic       int_pop_flags, vec_load, irq_ack, in_isr;
  logic [10:0] outs;
  int errors = 0;
  int checks = 0;

  hazard_seq_ctrl #(.RET_PENALTY(2), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .rd_en_E(rd_en_E), .wr_en_regf_E(wr_en_regf_E),
    .dest_E(dest_E), .RA_D(RA_D), .RB_D(RB_D), .uses_ra_D(uses_ra_D), .uses_rb_D(uses_rb_D),
    .branch_taken_E(branch_taken_E), .is_ret_E(is_ret_E), .irq(irq),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .ret_pc_load(ret_pc_load), .int_push_pc(int_push_pc), .int_push_flags(int_push_flags),
    .int_pop_flags(int_pop_flags), .vec_load(vec_load), .irq_ack(irq_ack), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  assign outs = {stall_F, stall_D, flush_D, flush_E, ret_pc_load, int_push_pc,
                 int_push_flags, int_pop_flags, vec_load, irq_ack, in_isr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    rd_en_E = 0; wr_en_regf_E = 0; uses_ra_D = 0; uses_rb_D = 0;
    branch_taken_E = 0; is_ret_E = 0; irq = 0;
    dest_E = 2'd0; RA_D = 2'd0; RB_D = 2'd0;
  endtask

  task automatic test_reset();
    clr_in();
    irq = 1; is_ret_E = 1; rd_en_E = 1; wr_en_regf_E = 1; uses_ra_D = 1;
    #2;
    checks++;
    if (outs !== 11'b0) begin errors++; $display("FAIL reset_outs: got %b want %b", outs, 11'b0); end
    tick(); tick();
    checks++;
    if (outs !== 11'b0) begin errors++; $display("FAIL reset_held: got %b want %b", outs, 11'b0); end
    reset = 1; clr_in();
    #1;
    checks++;
    if (outs !== 11'b0) begin errors++; $display("FAIL reset_release: got %b want %b", outs, 11'b0); end
  endtask

  task automatic test_load_use();
    tick(); clr_in();
    rd_en_E = 1; wr_en_regf_E = 1; dest_E = 2'd2; uses_rb_D = 1; RB_D = 2'd2;
    #1;
    checks++;
    if (outs !== 11'b11010000000) begin errors++; $display("FAIL lu_hit: got %b want %b", outs, 11'b11010000000); end
    tick(); clr_in();
    #1;
    checks++;
    if (outs !== 11'b0) begin errors++; $display("FAIL lu_release: got %b want %b", outs, 11'b0); end
    tick(); clr_in();
    rd_en_E = 1; wr_en_regf_E = 1; dest_E = 2'd2; uses_rb_D = 1; RB_D = 2'd1;
    #1;
    checks++;
    if (outs !== 11'b0) begin errors++; $display("FAIL lu_miss_rb: got %b want %b", outs, 11'b0); end
    tick(); clr_in();
    rd_en_E = 0; wr_en_regf_E = 1; dest_E = 2'd3; uses_ra_D = 1; RA_D = 2'd3;
    #1;
    checks++;
    if (outs !== 11'b0) begin errors++; $display("FAIL lu_no_read: got %b want %b", outs, 11'b0); end
    tick(); clr_in();
    rd_en_E = 1; wr_en_regf_E = 1; dest_E = 2'd3; uses_ra_D = 1; RA_D = 2'd3;
    #1;
    checks++;
    if (outs !== 11'b11010000000) begin errors++; $display("FAIL lu_hit_ra: got %b want %b", outs, 11'b11010000000); end
  endtask

  task automatic test_branch_lu();
    tick(); clr_in();
    branch_taken_E = 1; rd_en_E = 1; wr_en_regf_E = 1; dest_E = 2'd1; uses_ra_D = 1; RA_D = 2'd1;
    #1;
    checks++;
    if (outs !== 11'b00110000000) begin errors++; $display("FAIL branch_lu: got %b want %b", outs, 11'b00110000000); end
    tick(); clr_in();
    #1;
    checks++;
    if (outs !== 11'b0) begin errors++; $display("FAIL branch_one_cycle: got %b want %b", outs, 11'b0); end
  endtask

  task automatic test_ret();
    logic [10:0] exp [0:3];
    exp[0] = 11'b10110000000; exp[1] = 11'b10110000000;
    exp[2] = 11'b10111000000; exp[3] = 11'b00000000000;
    for (int i = 0; i < 4; i++) begin
      tick(); clr_in();
      if (i == 0) begin is_ret_E = 1; branch_taken_E = 1; end
      #1;
      checks++;
      if (outs !== exp[i]) begin errors++; $display("FAIL ret_t%0d: got %b want %b", i, outs, exp[i]); end
    end
  endtask

  task automatic test_irq();
    logic [10:0] exp [0:10];
    tick(); clr_in();
    rd_en_E = 1; wr_en_regf_E = 1; dest_E = 2'd1; uses_ra_D = 1; RA_D = 2'd1; irq = 1;
    #1;
    checks++;
    if (outs !== 11'b11010000000) begin errors++; $display("FAIL lu_over_irq: got %b want %b", outs, 11'b11010000000); end
    exp[0] = 11'b10100000000; exp[1] = 11'b10110000000; exp[2] = 11'b10110000000;
    exp[3] = 11'b10010100000; exp[4] = 11'b10010010000; exp[5] = 11'b00110000110;
    for (int i = 6; i < 11; i++) exp[i] = 11'b00000000001;
    for (int i = 0; i < 11; i++) begin
      tick(); clr_in(); irq = 1;
      #1;
      checks++;
      if (outs !== exp[i]) begin errors++; $display("FAIL irq_t%0d: got %b want %b", i, outs, exp[i]); end
    end
  endtask

  task automatic test_rti();
    logic [10:0] exp [0:7];
    exp[0] = 11'b10110000001; exp[1] = 11'b10110000001; exp[2] = 11'b10111001001;
    exp[3] = 11'b10100000000; exp[4] = 11'b10110000000; exp[5] = 11'b10110000000;
    exp[6] = 11'b10010100000; exp[7] = 11'b10010010000;
    for (int i = 0; i < 8; i++) begin
      tick(); clr_in(); irq = 1;
      if (i == 0) is_ret_E = 1;
      #1;
      checks++;
      if (outs !== exp[i]) begin errors++; $display("FAIL rti_t%0d: got %b want %b", i, outs, exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    reset = 0; irq = 0;
    #1;
    checks++;
    if (outs !== 11'b0) begin errors++; $display("FAIL rstmid_immediate: got %b want %b", outs, 11'b0); end
    tick();
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (outs !== 11'b0) begin errors++; $display("FAIL rstmid_quiet_%0d: got %b want %b", i, outs, 11'b0); end
    end
  endtask

  task automatic test_restart();
    logic [10:0] exp [0:6];
    exp[0] = 11'b10100000000; exp[1] = 11'b10110000000; exp[2] = 11'b10110000000;
    exp[3] = 11'b10010100000; exp[4] = 11'b10010010000; exp[5] = 11'b00110000110;
    exp[6] = 11'b00000000001;
    for (int i = 0; i < 7; i++) begin
      tick(); clr_in(); irq = 1;
      #1;
      checks++;
      if (outs !== exp[i]) begin errors++; $display("FAIL restart_t%0d: got %b want %b", i, outs, exp[i]); end
    end
    tick(); clr_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_lu();
    test_ret();
    test_irq();
    test_rti();
    test_reset_mid();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_seq_ctrl.md
Name: hazard_seq_ctrl

Overview:
Hazard and sequencing controller for the 8-bit pipeline. It drives stall/flush for the IF/ID and ID/EX registers, handling load-use stalls and taken-branch squashes. It also sequences multi-cycle RET and interrupt entry. It sits beside the ID/EX register and consumes the EX-stage control copies that register produces.

Parameters:
RET_PENALTY, 2, bubble cycles inserted after a RET reaches EX before the return PC is loaded (range 1..7)
DRAIN_CYCLES, 2, bubble cycles inserted on interrupt entry so older EX/MEM instructions retire (range 1..7)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low
rd_en_E  input  1  instruction in EX is a memory read
wr_en_regf_E  input  1  instruction in EX writes the register file
dest_E  input  2  destination register of the EX instruction
RA_D  input  2  decode source A
RB_D  input  2  decode source B
uses_ra_D  input  1  decode instruction reads RA
uses_rb_D  input  1  decode instruction reads RB
branch_taken_E  input  1  branch resolved taken in EX
is_ret_E  input  1  RET/RTI in EX
irq  input  1  level interrupt request, held until irq_ack
stall_F  output  1  hold PC
stall_D  output  1  hold IF/ID
flush_D  output  1  clear IF/ID
flush_E  output  1  clear ID/EX, feeds the ID/EX flush input
ret_pc_load  output  1  one-cycle pulse: PC <= popped return address
int_push_pc  output  1  one-cycle pulse: push PC of oldest unissued instruction
int_push_flags  output  1  one-cycle pulse: f_save
int_pop_flags  output  1  one-cycle pulse: f_restore, on RET completion while in_isr
vec_load  output  1  one-cycle pulse: PC <= interrupt vector
irq_ack  output  1  one-cycle pulse, same cycle as vec_load
in_isr  output  1  interrupt service active, masks further irq

Behaviour:
- Reset: state IDLE, counter 0, in_isr 0. Every output is 0 while reset is low. Reset mid-sequence aborts to IDLE with no further pulses.
- States: IDLE, RET_WAIT, INT_DRAIN, INT_PUSH_PC, INT_PUSH_FLG, INT_VEC. Outputs are combinational from state and inputs. State and counter are registered.
- IDLE priority, highest first: is_ret_E, branch_taken_E, load-use, irq.
- is_ret_E in IDLE:
  - Assert flush_D=1, flush_E=1, stall_F=1.
  - Counter <= RET_PENALTY-1, go to RET_WAIT.
- RET_WAIT:
  - Each cycle: stall_F=1, flush_D=1, flush_E=1.
  - When counter==0: ret_pc_load=1, int_pop_flags=in_isr, in_isr<=0, next state IDLE.
  - Otherwise counter decrements.
  - Total flush cycles = RET_PENALTY+1. ret_pc_load occurs RET_PENALTY cycles after the RET cycle.
- branch_taken_E in IDLE: flush_D=1, flush_E=1, stall_F=0, for 1 cycle. Load-use is suppressed that cycle.
- Load-use:
  - Condition: lu = rd_en_E & wr_en_regf_E & ((uses_ra_D & RA_D==dest_E) | (uses_rb_D & RB_D==dest_E)).
  - Response: stall_F=1, stall_D=1, flush_E=1 for exactly the cycles lu holds (normally 1).
  - flush_D=0.
- irq accepted in IDLE only when irq=1, in_isr=0, and no higher-priority event:
  - Go to INT_DRAIN with counter <= DRAIN_CYCLES-1.
  - The accept cycle itself asserts stall_F=1, flush_D=1.
- INT_DRAIN:
  - stall_F=1, flush_D=1, flush_E=1.
  - Counter decrements; at 0 go to INT_PUSH_PC.
- INT_PUSH_PC: int_push_pc=1, stall_F=1, flush_E=1, then INT_PUSH_FLG.
- INT_PUSH_FLG: int_push_flags=1, stall_F=1, flush_E=1, then INT_VEC.
- INT_VEC: vec_load=1, irq_ack=1, flush_D=1, flush_E=1, in_isr<=1, then IDLE.
- Interrupt entry latency: irq accept to vec_load = DRAIN_CYCLES+3 cycles.
- In non-IDLE states, branch_taken_E, is_ret_E, lu and irq are ignored. Only bubbles reach EX, so these are 0 in a correct system.
- irq dropped mid-sequence: the sequence completes anyway.
- irq still high after ack while in_isr=1: ignored. It is re-evaluated once in_isr clears, the cycle after RET completion.
- Simultaneous is_ret_E and branch_taken_E: treated as RET.
- Simultaneous lu and irq: the lu stall is taken and the irq waits.

Test Plan:
- Load-use: rd_en_E=1, wr_en_regf_E=1, dest_E=2, uses_rb_D=1, RB_D=2 for 1 cycle. Expect stall_F=stall_D=flush_E=1 that cycle only, flush_D=0. Repeat with RB_D=1: all outputs 0.
- Branch plus load-use in the same cycle: expect flush_D=flush_E=1, stall_F=stall_D=0 for one cycle.
- RET, RET_PENALTY=2: is_ret_E pulse at cycle t. Expect flush_D=1 during t..t+2 and ret_pc_load=1 only at t+2. int_pop_flags=0 when in_isr=0.
- Interrupt, DRAIN_CYCLES=2: irq rises at t.
  - Expect int_push_pc at t+3, int_push_flags at t+4, vec_load=irq_ack=1 at t+5, in_isr=1 from t+6.
  - Keep irq high through t+10: no second entry.
- RTI path: with in_isr=1, pulse is_ret_E. Expect int_pop_flags=ret_pc_load=1 together and in_isr=0 the next cycle. A held irq is then re-accepted the following cycle.
- Reset mid-op: drop reset during INT_PUSH_FLG. Expect all outputs 0 immediately and no vec_load after release. Re-asserting irq restarts a full entry sequence.
